// File: rtl/fc_pkg.sv
// Shared types for the fully-connected output path: the word type, the
// post-MAC FSM states and the 33-to-32-bit saturating add helper.
package fc_pkg;

   typedef logic signed [31:0] word_t;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      EMIT    = 2'd1,
      WAIT    = 2'd2
   } fc_state_e;

   localparam word_t SAT_MAX = 32'sh7FFF_FFFF;
   localparam word_t SAT_MIN = 32'sh8000_0000;

   // Overflow shows up as the two top bits of the 33-bit sum disagreeing.
   function automatic word_t sat_add32(input logic signed [32:0] sum);
      if (sum[32] != sum[31]) begin
         return sum[32] ? SAT_MIN : SAT_MAX;
      end
      return word_t'(sum[31:0]);
   endfunction

endpackage

// File: rtl/fc_bias_regfile.sv
// Per-neuron bias table: one synchronous write port, one combinational read
// port. A same-cycle write and read of one index returns the old value.
module fc_bias_regfile
   import fc_pkg::*;
#(
   parameter int unsigned DEPTH = 10,
   parameter int unsigned IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  word_t            wr_data_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output word_t            rd_data_o
);

   localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

   word_t mem_q [DEPTH];

   // NOTE: the table is a plain register array, so clearing it on reset is
   // cheap and keeps the first vector after reset free of stale biases.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i && ({1'b0, wr_idx_i} < DEPTH_L)) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_o = ({1'b0, rd_idx_i} < DEPTH_L) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/fc_bias_act.sv
// Post-MAC stage: adds a per-neuron bias to each accumulation, saturates,
// optionally applies ReLU and packs a batch_size x bias_size result vector.
module fc_bias_act
   import fc_pkg::*;
#(
   parameter int unsigned batch_size = 1,
   parameter int unsigned bias_size  = 10,
   parameter bit          RELU_EN    = 1'b1,
   localparam int unsigned IDX_W = (bias_size  > 1) ? $clog2(bias_size)  : 1,
   localparam int unsigned B_W   = (batch_size > 1) ? $clog2(batch_size) : 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    MacFba_acc_valid,
   input  word_t                                   MacFba_acc,
   input  logic                                    MacFba_acc_last,
   output logic                                    FbaMac_acc_ready,
   input  logic                                    NcFba_biasEn,
   input  logic [IDX_W-1:0]                        NcFba_biasIdx,
   input  word_t                                   NcFba_bias,
   output logic                                    FcNwc_result_en,
   output logic [batch_size-1:0][bias_size-1:0][31:0] FcNwc_result,
   input  logic                                    NwcNc_done,
   output logic                                    FbaNc_err
);

   localparam logic [IDX_W-1:0] N_LAST = IDX_W'(bias_size - 1);
   localparam logic [B_W-1:0]   B_LAST = B_W'(batch_size - 1);

   fc_state_e        state_q, state_d;
   logic [IDX_W-1:0] n_q, n_d;
   logic [B_W-1:0]   b_q, b_d;

   // One-deep pipeline between the adder and the result register.
   logic             stg_wr_q;
   logic             stg_fin_q;
   logic [IDX_W-1:0] stg_n_q;
   logic [B_W-1:0]   stg_b_q;
   word_t            stg_val_q;

   logic [batch_size-1:0][bias_size-1:0][31:0] result_q;
   logic             err_q;

   word_t              bias_rd;
   logic               xfer;
   logic               at_final;
   logic               frame_bad;
   logic               wr_ok;
   logic signed [32:0] sum_ext;
   word_t              sat_val;
   word_t              act_val;

   fc_bias_regfile #(
      .DEPTH (bias_size),
      .IDX_W (IDX_W)
   ) u_bias (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (NcFba_biasEn),
      .wr_idx_i  (NcFba_biasIdx),
      .wr_data_i (NcFba_bias),
      .rd_idx_i  (n_q),
      .rd_data_o (bias_rd)
   );

   // Ready also drops while the final element sits in the pipeline, so it
   // stays a pure function of registered state.
   assign FbaMac_acc_ready = (state_q == COLLECT) && !stg_fin_q;
   assign FcNwc_result_en  = (state_q == EMIT);
   assign FcNwc_result     = result_q;
   assign FbaNc_err        = err_q;

   assign xfer      = MacFba_acc_valid && FbaMac_acc_ready;
   assign at_final  = (n_q == N_LAST) && (b_q == B_LAST);
   assign frame_bad = (MacFba_acc_last != at_final);
   assign wr_ok     = !(MacFba_acc_last && !at_final);

   assign sum_ext = {MacFba_acc[31], MacFba_acc} + {bias_rd[31], bias_rd};
   assign sat_val = sat_add32(sum_ext);
   assign act_val = (RELU_EN && sat_val[31]) ? '0 : sat_val;

   // NOTE: every combinational output gets a default before the case so no
   // path through the block leaves it unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      b_d     = b_q;

      if (xfer) begin
         if (frame_bad || at_final) begin
            n_d = '0;
            b_d = '0;
         end else if (n_q == N_LAST) begin
            n_d = '0;
            b_d = b_q + 1'b1;
         end else begin
            n_d = n_q + 1'b1;
         end
      end

      case (state_q)
         COLLECT: if (stg_fin_q)  state_d = EMIT;
         EMIT:                    state_d = WAIT;
         WAIT:    if (NwcNc_done) state_d = COLLECT;
         default:                 state_d = COLLECT;
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= COLLECT;
         n_q       <= '0;
         b_q       <= '0;
         stg_wr_q  <= 1'b0;
         stg_fin_q <= 1'b0;
         stg_n_q   <= '0;
         stg_b_q   <= '0;
         stg_val_q <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         b_q       <= b_d;
         stg_wr_q  <= xfer && wr_ok;
         stg_fin_q <= xfer && at_final && MacFba_acc_last;
         stg_n_q   <= n_q;
         stg_b_q   <= b_q;
         stg_val_q <= act_val;
         if (stg_wr_q) begin
            result_q[stg_b_q][stg_n_q] <= stg_val_q;
         end
         if (xfer && frame_bad) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fc_bias_act.sv
// Scoreboard bench for fc_bias_act: three instances (ReLU, pass-through,
// batch of two) share one clock; a monitor checks every emitted vector.
module tb_fc_bias_act;
   import fc_pkg::*;

   typedef logic [19:0][31:0] vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst   [3];
   logic       valid [3];
   word_t      acc   [3];
   logic       last  [3];
   logic       ben   [3];
   logic [3:0] bidx  [3];
   word_t      bias  [3];
   logic       done  [3];
   logic       ready [3];
   logic       en    [3];
   logic       err   [3];

   logic [0:0][9:0][31:0] res0;
   logic [0:0][9:0][31:0] res1;
   logic [1:0][9:0][31:0] res2;

   word_t bm [3][10];
   vec_t  q0[$];
   vec_t  q1[$];
   vec_t  q2[$];

   int n_checks = 0;
   int n_errors = 0;

   fc_bias_act #(.batch_size(1), .bias_size(10), .RELU_EN(1'b1)) dut0 (
      .clk(clk), .rst(rst[0]), .MacFba_acc_valid(valid[0]), .MacFba_acc(acc[0]),
      .MacFba_acc_last(last[0]), .FbaMac_acc_ready(ready[0]), .NcFba_biasEn(ben[0]),
      .NcFba_biasIdx(bidx[0]), .NcFba_bias(bias[0]), .FcNwc_result_en(en[0]),
      .FcNwc_result(res0), .NwcNc_done(done[0]), .FbaNc_err(err[0]));

   fc_bias_act #(.batch_size(1), .bias_size(10), .RELU_EN(1'b0)) dut1 (
      .clk(clk), .rst(rst[1]), .MacFba_acc_valid(valid[1]), .MacFba_acc(acc[1]),
      .MacFba_acc_last(last[1]), .FbaMac_acc_ready(ready[1]), .NcFba_biasEn(ben[1]),
      .NcFba_biasIdx(bidx[1]), .NcFba_bias(bias[1]), .FcNwc_result_en(en[1]),
      .FcNwc_result(res1), .NwcNc_done(done[1]), .FbaNc_err(err[1]));

   fc_bias_act #(.batch_size(2), .bias_size(10), .RELU_EN(1'b1)) dut2 (
      .clk(clk), .rst(rst[2]), .MacFba_acc_valid(valid[2]), .MacFba_acc(acc[2]),
      .MacFba_acc_last(last[2]), .FbaMac_acc_ready(ready[2]), .NcFba_biasEn(ben[2]),
      .NcFba_biasIdx(bidx[2]), .NcFba_bias(bias[2]), .FcNwc_result_en(en[2]),
      .FcNwc_result(res2), .NwcNc_done(done[2]), .FbaNc_err(err[2]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic push(input int d, input vec_t v);
      case (d)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   // Monitor: pops one expected vector per result_en pulse.
   task automatic mon(input int d);
      vec_t got;
      vec_t exp;
      int   depth;
      int   nel;
      case (d)
         0:       begin got = vec_t'(res0); depth = q0.size(); end
         1:       begin got = vec_t'(res1); depth = q1.size(); end
         default: begin got = vec_t'(res2); depth = q2.size(); end
      endcase
      if (depth == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL dut%0d unexpected result_en: got 1, required 0", d);
         return;
      end
      case (d)
         0:       exp = q0.pop_front();
         1:       exp = q1.pop_front();
         default: exp = q2.pop_front();
      endcase
      nel = (d == 2) ? 20 : 10;
      for (int i = 0; i < nel; i++) begin
         check($sformatf("dut%0d elem[%0d][%0d]", d, i / 10, i % 10), got[i], exp[i]);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (en[d]) mon(d);
         end
      end
   end

   task automatic wbias(input int d, input logic [3:0] idx, input word_t v);
      ben[d] = 1'b1; bidx[d] = idx; bias[d] = v;
      bm[d][idx] = v;
      @(negedge clk);
      ben[d] = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the word transferred.
   task automatic send(input int d, input word_t a, input logic l);
      int t;
      valid[d] = 1'b1; acc[d] = a; last[d] = l;
      t = 0;
      while (!ready[d] && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!ready[d]) begin
         n_checks++;
         n_errors++;
         $display("FAIL dut%0d send timeout: ready got 0, required 1", d);
         valid[d] = 1'b0;
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic pulse_done(input int d);
      done[d] = 1'b1;
      @(negedge clk);
      done[d] = 1'b0;
   endtask

   task automatic finish_vec(input int d);
      int t;
      valid[d] = 1'b0; last[d] = 1'b0;
      t = 0;
      while (!en[d] && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!en[d]) begin
         n_checks++;
         n_errors++;
         $display("FAIL dut%0d result_en timeout: got 0, required 1", d);
      end
      @(negedge clk);
      pulse_done(d);
   endtask

   initial begin
      vec_t e;
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; valid[d] = 1'b0; acc[d] = '0; last[d] = 1'b0;
         ben[d] = 1'b0; bidx[d] = '0; bias[d] = '0; done[d] = 1'b0;
         for (int i = 0; i < 10; i++) bm[d][i] = '0;
      end
      repeat (3) @(negedge clk);
      check("reset ready", 32'(ready[0]), 32'd1);
      check("reset result_en", 32'(en[0]), 32'd0);
      check("reset err", 32'(err[0]), 32'd0);
      check("reset result", 32'(|res0), 32'd0);
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      @(negedge clk);

      // 1: biases of 100, words 0..9, exact emit latency and hold in WAIT
      for (int i = 0; i < 10; i++) wbias(0, 4'(i), 32'sd100);
      e = '0;
      for (int k = 0; k < 10; k++) e[k] = 32'(100 + k);
      push(0, e);
      for (int k = 0; k < 10; k++) send(0, word_t'(k), k == 9);
      valid[0] = 1'b0; last[0] = 1'b0;
      check("t1 result_en one cycle after", 32'(en[0]), 32'd0);
      check("t1 ready after final", 32'(ready[0]), 32'd0);
      @(negedge clk);
      check("t1 result_en two cycles after", 32'(en[0]), 32'd1);
      @(negedge clk);
      check("t1 result_en single pulse", 32'(en[0]), 32'd0);
      repeat (3) begin
         check("t1 ready in wait", 32'(ready[0]), 32'd0);
         @(negedge clk);
      end
      pulse_done(0);
      check("t1 ready after done", 32'(ready[0]), 32'd1);

      // 2: saturation and ReLU on dut0
      wbias(0, 4'd0, 32'sh100);
      wbias(0, 4'd1, 32'sd2);
      e = '0;
      e[0] = 32'h7FFF_FFFF;
      e[1] = 32'h0;
      e[2] = 32'h0;
      e[3] = 32'h0;
      for (int k = 4; k < 10; k++) e[k] = 32'(100 + k);
      push(0, e);
      send(0, 32'sh7FFF_FFF0, 1'b0);
      send(0, -32'sd5, 1'b0);
      send(0, 32'sh8000_0000, 1'b0);
      send(0, -32'sd200, 1'b0);
      for (int k = 4; k < 10; k++) send(0, word_t'(k), k == 9);
      finish_vec(0);

      // 2: saturation without ReLU on dut1
      wbias(1, 4'd0, 32'sh100);
      wbias(1, 4'd1, 32'sd2);
      wbias(1, 4'd2, -32'sd1);
      e = '0;
      e[0] = 32'h7FFF_FFFF;
      e[1] = 32'hFFFF_FFFD;
      e[2] = 32'h8000_0000;
      for (int k = 3; k < 10; k++) e[k] = 32'(k);
      push(1, e);
      send(1, 32'sh7FFF_FFF0, 1'b0);
      send(1, -32'sd5, 1'b0);
      send(1, 32'sh8000_0000, 1'b0);
      for (int k = 3; k < 10; k++) send(1, word_t'(k), k == 9);
      finish_vec(1);

      // 3: bias write colliding with the n=3 transfer uses the old bias
      wbias(0, 4'd3, 32'sd1);
      for (int pass = 0; pass < 2; pass++) begin
         e = '0;
         for (int k = 0; k < 10; k++) e[k] = 32'(k) + bm[0][k];
         e[3] = (pass == 0) ? 32'd11 : 32'd17;
         push(0, e);
         for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
               if (pass == 0) begin
                  ben[0] = 1'b1; bidx[0] = 4'd3; bias[0] = 32'sd7;
               end
               send(0, 32'sd10, 1'b0);
               ben[0] = 1'b0;
               bm[0][3] = 32'sd7;
            end else begin
               send(0, word_t'(k), k == 9);
            end
         end
         finish_vec(0);
      end

      // 4: early last -> sticky error, no emit, counters back at 0
      for (int k = 0; k < 5; k++) send(0, word_t'(k), 1'b0);
      send(0, 32'sd5, 1'b1);
      valid[0] = 1'b0; last[0] = 1'b0;
      check("t4 err after early last", 32'(err[0]), 32'd1);
      check("t4 ready after early last", 32'(ready[0]), 32'd1);
      repeat (4) @(negedge clk);
      e = '0;
      for (int k = 0; k < 10; k++) e[k] = 32'(20 + k) + bm[0][k];
      push(0, e);
      for (int k = 0; k < 10; k++) send(0, word_t'(20 + k), k == 9);
      finish_vec(0);
      check("t4 err sticky", 32'(err[0]), 32'd1);

      // 5: reset mid-vector drops the partial vector and the bias table
      for (int k = 0; k < 4; k++) send(0, word_t'(50 + k), 1'b0);
      valid[0] = 1'b0;
      rst[0] = 1'b1;
      @(negedge clk);
      check("t5 ready in reset", 32'(ready[0]), 32'd1);
      check("t5 result_en in reset", 32'(en[0]), 32'd0);
      check("t5 err cleared", 32'(err[0]), 32'd0);
      check("t5 result cleared", 32'(|res0), 32'd0);
      rst[0] = 1'b0;
      for (int i = 0; i < 10; i++) bm[0][i] = '0;
      @(negedge clk);
      e = '0;
      for (int k = 0; k < 10; k++) e[k] = 32'(3 * k);
      push(0, e);
      for (int k = 0; k < 10; k++) send(0, word_t'(3 * k), k == 9);
      finish_vec(0);

      // 6: batch of two, held word during WAIT consumed only after done
      for (int i = 0; i < 10; i++) wbias(2, 4'(i), word_t'(i * 1000));
      e = '0;
      for (int i = 0; i < 20; i++) e[i] = 32'(i + (i % 10) * 1000);
      push(2, e);
      for (int i = 0; i < 20; i++) send(2, word_t'(i), i == 19);
      valid[2] = 1'b0; last[2] = 1'b0;
      repeat (3) @(negedge clk);
      valid[2] = 1'b1; acc[2] = 32'sd555; last[2] = 1'b0;
      repeat (5) begin
         check("t6 ready while held", 32'(ready[2]), 32'd0);
         @(negedge clk);
      end
      pulse_done(2);
      check("t6 ready after done", 32'(ready[2]), 32'd1);
      e = '0;
      e[0] = 32'd555;
      for (int i = 1; i < 20; i++) e[i] = 32'(i + (i % 10) * 1000);
      push(2, e);
      send(2, 32'sd555, 1'b0);
      for (int i = 1; i < 20; i++) send(2, word_t'(i), i == 19);
      finish_vec(2);

      repeat (5) @(negedge clk);
      check("dut0 queue drained", 32'(q0.size()), 32'd0);
      check("dut1 queue drained", 32'(q1.size()), 32'd0);
      check("dut2 queue drained", 32'(q2.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
